tri_assembler: RTL and testbench

Triangle assembly stage directly downstream of the 96-bit vertex FIFO. Pops vertices from the FIFO's show-ahead read port and groups them into triangles in list or strip mode. Presents each triangle as three registered vertices on a valid/ready interface to the rasterizer setup stage. Keeps a running count of emitted triangles.

---
 rtl/tri_pkg.sv | 20 ++
 rtl/tri_degen_cmp.sv | 13 +
 rtl/tri_assembler.sv | 140 ++++++++++++++
 tb/tb_tri_assembler.sv | 229 ++++++++++++++++++++++
 4 files changed

// File: rtl/tri_pkg.sv
// rtl/tri_pkg.sv - shared types and constants for the triangle assembler
package tri_pkg;

    typedef struct packed {
        logic [31:0] x;
        logic [31:0] y;
        logic [31:0] z;
    } vertex_t;

    typedef enum logic [1:0] {
        FILL0 = 2'd0,
        FILL1 = 2'd1,
        FILL2 = 2'd2,
        EMIT  = 2'd3
    } asm_state_t;

    localparam logic MODE_LIST  = 1'b0;
    localparam logic MODE_STRIP = 1'b1;

endpackage

// File: rtl/tri_degen_cmp.sv
// rtl/tri_degen_cmp.sv - combinational three-way vertex equality for degenerate culling
module tri_degen_cmp
    import tri_pkg::*;
(
    input  vertex_t va,
    input  vertex_t vb,
    input  vertex_t vin,
    output logic    degen
);

    assign degen = (vin == va) || (vin == vb) || (va == vb);

endmodule

// File: rtl/tri_assembler.sv
// rtl/tri_assembler.sv - groups FIFO vertices into list/strip triangles; DEGEN_CULL_EN adds degenerate culling
module tri_assembler
    import tri_pkg::*;
#(
    parameter int VBITS   = 96,
    parameter int CNTBITS = 16
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               fifo_empty,
    input  logic [VBITS-1:0]   fifo_dout,
    output logic               fifo_rd,
    input  logic               strip_mode,
    input  logic               flush,
    output logic               tri_valid,
    input  logic               tri_ready,
    output logic [VBITS-1:0]   tri_v0,
    output logic [VBITS-1:0]   tri_v1,
    output logic [VBITS-1:0]   tri_v2,
    output logic [CNTBITS-1:0] tri_count
`ifdef DEGEN_CULL_EN
   ,output logic [CNTBITS-1:0] culled_count
`endif
);

    asm_state_t       state, next_state;
    logic [VBITS-1:0] va, vb, vc;
    logic             parity;
    logic             mode_q;
    logic             degen;

`ifdef DEGEN_CULL_EN
    tri_degen_cmp u_degen_cmp (
        .va    (va),
        .vb    (vb),
        .vin   (fifo_dout),
        .degen (degen)
    );
`else
    assign degen = 1'b0;
`endif

    assign tri_valid = (state == EMIT);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= FILL0;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state = state;
        fifo_rd    = 1'b0;
        if (flush) begin
            next_state = FILL0;
        end else begin
            case (state)
                FILL0: if (!fifo_empty) begin
                    fifo_rd    = 1'b1;
                    next_state = FILL1;
                end
                FILL1: if (!fifo_empty) begin
                    fifo_rd    = 1'b1;
                    next_state = FILL2;
                end
                FILL2: if (!fifo_empty) begin
                    fifo_rd = 1'b1;
                    // a culled triangle takes the accept path without visiting EMIT
                    if (!degen) begin
                        next_state = EMIT;
                    end else begin
                        next_state = (mode_q == MODE_STRIP) ? FILL2 : FILL0;
                    end
                end
                EMIT: if (tri_ready) begin
                    next_state = (mode_q == MODE_STRIP) ? FILL2 : FILL0;
                end
                default: next_state = FILL0;
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            va        <= '0;
            vb        <= '0;
            vc        <= '0;
            parity    <= 1'b0;
            mode_q    <= MODE_LIST;
            tri_v0    <= '0;
            tri_v1    <= '0;
            tri_v2    <= '0;
            tri_count <= '0;
`ifdef DEGEN_CULL_EN
            culled_count <= '0;
`endif
        end else if (flush) begin
            parity <= 1'b0;
        end else begin
            case (state)
                FILL0: begin
                    mode_q <= strip_mode;
                    parity <= 1'b0;
                    if (fifo_rd) va <= fifo_dout;
                end
                FILL1: if (fifo_rd) vb <= fifo_dout;
                FILL2: if (fifo_rd) begin
                    vc <= fifo_dout;
                    if (degen) begin
`ifdef DEGEN_CULL_EN
                        culled_count <= culled_count + 1'b1;
`endif
                        if (mode_q == MODE_STRIP) begin
                            va     <= vb;
                            vb     <= fifo_dout;
                            parity <= ~parity;
                        end
                    end else begin
                        // odd strip triangles swap the first two vertices to keep winding
                        tri_v0 <= parity ? vb : va;
                        tri_v1 <= parity ? va : vb;
                        tri_v2 <= fifo_dout;
                    end
                end
                EMIT: if (tri_ready) begin
                    tri_count <= tri_count + 1'b1;
                    if (mode_q == MODE_STRIP) begin
                        va     <= vb;
                        vb     <= vc;
                        parity <= ~parity;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_tri_assembler.sv
// tb/tb_tri_assembler.sv - scoreboard bench for tri_assembler with a behavioural FIFO
module tb_tri_assembler;

    logic        clk;
    logic        reset;
    logic        fifo_empty;
    logic [95:0] fifo_dout;
    logic        fifo_rd;
    logic        strip_mode;
    logic        flush;
    logic        tri_valid;
    logic        tri_ready;
    logic [95:0] tri_v0, tri_v1, tri_v2;
    logic [15:0] tri_count;
`ifdef DEGEN_CULL_EN
    logic [15:0] culled_count;
`endif

    tri_assembler dut (
        .clk          (clk),
        .reset        (reset),
        .fifo_empty   (fifo_empty),
        .fifo_dout    (fifo_dout),
        .fifo_rd      (fifo_rd),
        .strip_mode   (strip_mode),
        .flush        (flush),
        .tri_valid    (tri_valid),
        .tri_ready    (tri_ready),
        .tri_v0       (tri_v0),
        .tri_v1       (tri_v1),
        .tri_v2       (tri_v2),
        .tri_count    (tri_count)
`ifdef DEGEN_CULL_EN
       ,.culled_count (culled_count)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    logic [95:0] mem [0:63];
    int          wr_ptr = 0;
    int          rd_ptr = 0;
    assign fifo_empty = (rd_ptr == wr_ptr);
    assign fifo_dout  = mem[rd_ptr[5:0]];

    always @(posedge clk) begin
        if (fifo_rd) rd_ptr <= rd_ptr + 1;
    end

    int checks   = 0;
    int failures = 0;
    int valid_cycles = 0;
    logic [287:0] exp_q [$];
    logic [15:0]  exp_tri_count = 16'd0;

    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic [95:0] mkv(input int i);
        return {32'(i * 3 + 1), 32'(i * 7 + 2), 32'(i * 11 + 3)};
    endfunction

    task automatic push(input logic [95:0] v);
        mem[wr_ptr[5:0]] = v;
        wr_ptr = wr_ptr + 1;
    endtask

    task automatic expect_tri(input logic [95:0] a, input logic [95:0] b, input logic [95:0] c);
        exp_q.push_back({a, b, c});
        exp_tri_count = exp_tri_count + 16'd1;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_drain(input string tag);
        for (int i = 0; i < 60 && exp_q.size() != 0; i++) @(negedge clk);
        check({tag, "_drain"}, 128'(exp_q.size()), 128'd0);
        repeat (3) @(negedge clk);
        check({tag, "_tri_count"}, 128'(tri_count), 128'(exp_tri_count));
    endtask

    task automatic wait_valid(input string tag);
        int n;
        n = 0;
        while (!tri_valid && n < 30) begin
            @(negedge clk);
            n++;
        end
        check({tag, "_valid_timeout"}, 128'(tri_valid), 128'd1);
    endtask

    always @(negedge clk) begin
        logic [287:0] e;
        if (tri_valid) valid_cycles++;
        if (reset && tri_valid && tri_ready) begin
            if (exp_q.size() == 0) begin
                check("unexpected_tri", 128'(tri_v0), 128'd0);
            end else begin
                e = exp_q.pop_front();
                check("tri_v0", 128'(tri_v0), 128'(e[287:192]));
                check("tri_v1", 128'(tri_v1), 128'(e[191:96]));
                check("tri_v2", 128'(tri_v2), 128'(e[95:0]));
            end
        end
    end

    initial begin
        int vc0;
        reset = 1'b0;
        strip_mode = 1'b0;
        flush = 1'b0;
        tri_ready = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        check("rst_tri_valid", 128'(tri_valid), 128'd0);
        check("rst_fifo_rd", 128'(fifo_rd), 128'd0);
        check("rst_tri_count", 128'(tri_count), 128'd0);
        check("rst_tri_v0", 128'(tri_v0), 128'd0);
`ifdef DEGEN_CULL_EN
        check("rst_culled", 128'(culled_count), 128'd0);
`endif
        reset = 1'b1;
        step();

        // list: single triangle, valid for exactly one cycle
        vc0 = valid_cycles;
        push(mkv(1)); push(mkv(2)); push(mkv(3));
        expect_tri(mkv(1), mkv(2), mkv(3));
        repeat (3) @(posedge clk);
        #1;
        check("list_latency_valid", 128'(tri_valid), 128'd1);
        wait_drain("list");
        check("list_valid_cycles", 128'(valid_cycles - vc0), 128'd1);

        // backpressure with more vertices waiting in the FIFO
        step();
        tri_ready = 1'b0;
        for (int i = 10; i < 16; i++) push(mkv(i));
        expect_tri(mkv(10), mkv(11), mkv(12));
        expect_tri(mkv(13), mkv(14), mkv(15));
        wait_valid("bp");
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check("bp_valid", 128'(tri_valid), 128'd1);
            check("bp_fifo_rd", 128'(fifo_rd), 128'd0);
            check("bp_v0_stable", 128'(tri_v0), 128'(mkv(10)));
            check("bp_v2_stable", 128'(tri_v2), 128'(mkv(12)));
        end
        step();
        tri_ready = 1'b1;
        wait_drain("bp");

        // strip
        step();
        strip_mode = 1'b1;
        for (int i = 20; i < 25; i++) push(mkv(i));
        expect_tri(mkv(20), mkv(21), mkv(22));
        expect_tri(mkv(22), mkv(21), mkv(23));
        expect_tri(mkv(22), mkv(23), mkv(24));
        wait_drain("strip");
        step();
        flush = 1'b1;
        strip_mode = 1'b0;
        step();
        flush = 1'b0;

        // underflow stall with partial vertices held
        push(mkv(30)); push(mkv(31));
        repeat (3) step();
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            check("uf_fifo_rd", 128'(fifo_rd), 128'd0);
            check("uf_valid", 128'(tri_valid), 128'd0);
        end
        step();
        push(mkv(32));
        expect_tri(mkv(30), mkv(31), mkv(32));
        wait_drain("underflow");

        // flush discards a partial triangle
        step();
        push(mkv(40)); push(mkv(41));
        repeat (3) step();
        flush = 1'b1;
        step();
        flush = 1'b0;
        push(mkv(42)); push(mkv(43)); push(mkv(44));
        expect_tri(mkv(42), mkv(43), mkv(44));
        wait_drain("flush");

        // degenerate triangle
        step();
        push(mkv(50)); push(mkv(50)); push(mkv(51));
`ifdef DEGEN_CULL_EN
        vc0 = valid_cycles;
        repeat (10) step();
        check("degen_no_valid", 128'(valid_cycles - vc0), 128'd0);
        check("degen_culled", 128'(culled_count), 128'd1);
`else
        expect_tri(mkv(50), mkv(50), mkv(51));
`endif
        wait_drain("degen");

        // asynchronous reset while a triangle is pending
        step();
        tri_ready = 1'b0;
        push(mkv(60)); push(mkv(61)); push(mkv(62));
        wait_valid("arst");
        #2;
        reset = 1'b0;
        #1;
        check("arst_valid", 128'(tri_valid), 128'd0);
        check("arst_tri_count", 128'(tri_count), 128'd0);
        check("arst_tri_v0", 128'(tri_v0), 128'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
